// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares one single-port on-chip RAM (registered address,
// unregistered q) between two Avalon-MM masters, one access per cycle.
// Default build: round-robin arbitration with a bounded hold of HOLD_MAX grants.
// Define ONCHIP_ARB_FIXED_PRIO_EN for fixed priority, where master 0 always wins.
`timescale 1ns/1ps

module onchip_mem_arbiter #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned HOLD_MAX = 4,
  localparam int unsigned BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             last_owner_q, last_owner_d;
  logic [1:0]       rd_tag_q, rd_tag_d;

  logic             req0, req1;
  logic             gnt0, gnt1;
  logic             hold_lt;
  logic [CNT_W-1:0] hold_inc;

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign hold_lt  = (hold_cnt_q < HOLD_MAX_C);
  assign hold_inc = hold_lt ? (hold_cnt_q + CNT_W'(1)) : hold_cnt_q;

  // Grant for the current cycle; nothing is granted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
      if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
`else
      case (state_q)
        ST_OWN0: begin
          if (req0 && (!req1 || hold_lt)) begin
            gnt0 = 1'b1;
          end else if (req1) begin
            gnt1 = 1'b1;
          end
        end
        ST_OWN1: begin
          if (req1 && (!req0 || hold_lt)) begin
            gnt1 = 1'b1;
          end else if (req0) begin
            gnt0 = 1'b1;
          end
        end
        default: begin
          // From idle, a tie goes to the master that did not own the last grant.
          if (req0 && req1) begin
            gnt0 = last_owner_q;
            gnt1 = ~last_owner_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
`endif
    end
  end

  // Next owner, saturating hold count, last owner and read ownership tags.
  always_comb begin
    state_d      = ST_IDLE;
    hold_cnt_d   = '0;
    last_owner_d = last_owner_q;
    if (gnt0) begin
      state_d      = ST_OWN0;
      hold_cnt_d   = (state_q == ST_OWN0) ? hold_inc : CNT_W'(1);
      last_owner_d = 1'b0;
    end else if (gnt1) begin
      state_d      = ST_OWN1;
      hold_cnt_d   = (state_q == ST_OWN1) ? hold_inc : CNT_W'(1);
      last_owner_d = 1'b1;
    end
    // A simultaneous write takes precedence, so such a read gets no response.
    rd_tag_d = {gnt1 & m1_read & ~m1_write, gnt0 & m0_read & ~m0_write};
  end

  // Arbiter state and read tags; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      last_owner_q <= 1'b1;
      rd_tag_q     <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  assign m0_waitrequest   = ~reset_n | (req0 & ~gnt0);
  assign m1_waitrequest   = ~reset_n | (req1 & ~gnt1);
  assign m0_readdatavalid = reset_n & rd_tag_q[0];
  assign m1_readdatavalid = reset_n & rd_tag_q[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
  assign mem_address    = gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign mem_clken      = 1'b1;

endmodule
